// File: rtl/pll_cfg_if.sv
// Avalon-MM management bus between the PLL reconfig writer (master) and the
// altera_pll_reconfig slave.
//   address     6  reconfig register address
//   write/read  1  transfer strobes
//   writedata  32  write data
//   readdata   32  read data, valid when read & !waitrequest
//   waitrequest 1  slave stall
interface pll_cfg_if;
  logic [5:0]  address;
  logic        write;
  logic        read;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        waitrequest;

  modport master (output address, write, read, writedata,
                  input  readdata, waitrequest);
  modport slave  (input  address, write, read, writedata,
                  output readdata, waitrequest);
endinterface

// File: rtl/pll_cfg_writer.sv
// PLL reconfiguration writer. On cfg_start (in IDLE) it latches N/M/C and
// writes MODE=polling, N, M, one C counter and START, polls STATUS until
// bit 0 is set, then waits for two consecutive lock cycles.
//   refclk, rst_n        management clock, async active-low reset
//   cfg_start            1-cycle request, sampled only in IDLE
//   cfg_n, cfg_m, cfg_c  counter words
//   pll_locked           PLL lock, already synchronous to refclk
//   busy, done, error    status; done/error are 1-cycle pulses
//   mgmt                 Avalon-MM master port
module pll_cfg_writer #(
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int CNT_W          = 16
) (
  input  logic        refclk,
  input  logic        rst_n,
  input  logic        cfg_start,
  input  logic [17:0] cfg_n,
  input  logic [17:0] cfg_m,
  input  logic [22:0] cfg_c,
  input  logic        pll_locked,
  output logic        busy,
  output logic        done,
  output logic        error,
  pll_cfg_if.master   mgmt
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WR     = 3'd1;
  localparam logic [2:0] S_WR_GAP = 3'd2;
  localparam logic [2:0] S_RD     = 3'd3;
  localparam logic [2:0] S_RD_GAP = 3'd4;
  localparam logic [2:0] S_LOCK   = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;
  localparam logic [2:0] S_ERR    = 3'd7;

  localparam logic [5:0] A_STATUS = 6'h01;
  localparam logic [2:0] NUM_WR   = 3'd5;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef struct packed {
    logic [17:0] n;
    logic [17:0] m;
    logic [22:0] c;
  } cfg_t;

  logic [2:0]       state;
  logic [2:0]       wr_idx;
  cfg_t             cfg;
  logic [CNT_W-1:0] tmo;
  logic             lock_prev;
  logic             tmo_hit;
  logic             unused_rd;

  assign tmo_hit   = (tmo >= TMO_LAST);
  assign unused_rd = ^mgmt.readdata[31:1];

  // Write sequence table: MODE, N, M, C, START.
  function automatic logic [5:0] wr_addr(input logic [2:0] idx);
    case (idx)
      3'd0:    wr_addr = 6'h00;
      3'd1:    wr_addr = 6'h03;
      3'd2:    wr_addr = 6'h04;
      3'd3:    wr_addr = 6'h05;
      default: wr_addr = 6'h02;
    endcase
  endfunction

  function automatic logic [31:0] wr_data(input logic [2:0] idx, input cfg_t c);
    case (idx)
      3'd1:    wr_data = {14'd0, c.n};
      3'd2:    wr_data = {14'd0, c.m};
      3'd3:    wr_data = {9'd0, c.c};
      default: wr_data = 32'd1;
    endcase
  endfunction

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      wr_idx         <= '0;
      cfg            <= '0;
      tmo            <= '0;
      lock_prev      <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      mgmt.write     <= 1'b0;
      mgmt.read      <= 1'b0;
      mgmt.address   <= '0;
      mgmt.writedata <= '0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        S_IDLE: if (cfg_start) begin
          cfg            <= '{n: cfg_n, m: cfg_m, c: cfg_c};
          busy           <= 1'b1;
          wr_idx         <= 3'd0;
          mgmt.write     <= 1'b1;
          mgmt.address   <= wr_addr(3'd0);
          mgmt.writedata <= 32'd1;
          state          <= S_WR;
        end
        S_WR: if (!mgmt.waitrequest) begin
          mgmt.write <= 1'b0;
          wr_idx     <= wr_idx + 3'd1;
          state      <= S_WR_GAP;
        end
        S_WR_GAP: if (wr_idx == NUM_WR) begin
          mgmt.read    <= 1'b1;
          mgmt.address <= A_STATUS;
          tmo          <= '0;
          state        <= S_RD;
        end else begin
          mgmt.write     <= 1'b1;
          mgmt.address   <= wr_addr(wr_idx);
          mgmt.writedata <= wr_data(wr_idx, cfg);
          state          <= S_WR;
        end
        S_RD: begin
          tmo <= tmo + CNT_W'(1);
          // Completed status read with done set wins over a coincident timeout.
          if (!mgmt.waitrequest && mgmt.readdata[0]) begin
            mgmt.read <= 1'b0;
            lock_prev <= 1'b0;
            state     <= S_LOCK;
          end else if (tmo_hit) begin
            mgmt.read <= 1'b0;
            busy      <= 1'b0;
            error     <= 1'b1;
            state     <= S_ERR;
          end else if (!mgmt.waitrequest) begin
            mgmt.read <= 1'b0;
            state     <= S_RD_GAP;
          end
        end
        S_RD_GAP: begin
          tmo <= tmo + CNT_W'(1);
          if (tmo_hit) begin
            busy  <= 1'b0;
            error <= 1'b1;
            state <= S_ERR;
          end else begin
            mgmt.read <= 1'b1;
            state     <= S_RD;
          end
        end
        S_LOCK: begin
          tmo       <= tmo + CNT_W'(1);
          lock_prev <= pll_locked;
          if (pll_locked && lock_prev) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else if (tmo_hit) begin
            busy  <= 1'b0;
            error <= 1'b1;
            state <= S_ERR;
          end
        end
        // One dead cycle so a cfg_start coinciding with the pulse is dropped.
        S_DONE, S_ERR: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
